// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package mult_share_arbiter_pkg;

  localparam int unsigned OP_W            = 8;
  localparam int unsigned RES_W           = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    winner,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  always_comb begin
    int unsigned j;
    j      = 0;
    winner = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        winner[j] = 1'b1;
        idx       = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one sequential 8x8 multiplier between NUM_REQ requesters.
// Optional WAIT timeout enabled by defining MULT_SHARE_ARB_TIMEOUT_EN.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [OP_W*NUM_REQ-1:0] a_in,
  input  logic [OP_W*NUM_REQ-1:0] b_in,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic [RES_W-1:0]        res_out,
  output logic                    err,
  output logic                    mult_ld,
  output logic [OP_W-1:0]         mult_a,
  output logic [OP_W-1:0]         mult_b,
  input  logic                    mult_rdy,
  input  logic [RES_W-1:0]        mult_res
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q, owner_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [OP_W-1:0]     a_q, b_q;
  logic [RES_W-1:0]    res_q;
  logic [NUM_REQ-1:0]  win_oh;
  logic [IdxW-1:0]     win_idx;
  logic                win_any;
  logic                timeout;

  rr_pick #(
    .N(NUM_REQ)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .winner(win_oh),
    .idx   (win_idx),
    .any   (win_any)
  );

`ifdef MULT_SHARE_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  // cnt_q counts completed WAIT cycles; the limit is hit in the TIMEOUT_CYC-th one.
  assign timeout = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StLoad) begin
        cnt_q <= '0;
      end else if (state_q == StWait && !mult_rdy && !timeout) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == StWait && !mult_rdy && timeout) begin
        err_q <= 1'b1;
      end else if (state_q == StDone) begin
        err_q <= 1'b0;
      end
    end
  end

  assign err = (state_q == StDone) && err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
  assign err                = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_any) state_d = StLoad;
      StLoad:  state_d = StWait;
      StWait:  if (mult_rdy || timeout) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (win_any) begin
            owner_q <= win_idx;
            gnt_q   <= win_oh;
            a_q     <= a_in[win_idx*OP_W +: OP_W];
            b_q     <= b_in[win_idx*OP_W +: OP_W];
          end
        end
        StWait: begin
          if (mult_rdy) begin
            res_q <= mult_res;
          end else if (timeout) begin
            res_q <= '0;
          end
        end
        StDone: begin
          gnt_q <= '0;
          ptr_q <= (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = (state_q == StDone) ? gnt_q : '0;
  assign mult_ld = (state_q == StLoad);
  assign mult_a  = a_q;
  assign mult_b  = b_q;
  assign res_out = res_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a 9-cycle multiplier model.
// Timeout scenario runs only when MULT_SHARE_ARB_TIMEOUT_EN is defined.
module tb_mult_share_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned TO  = 32;
  localparam int unsigned LAT = 9;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] a_in = '0;
  logic [8*N-1:0] b_in = '0;
  logic [N-1:0]   gnt, done;
  logic [15:0]    res_out;
  logic           err, mult_ld;
  logic [7:0]     mult_a, mult_b;
  logic           rdy_real = 1'b0, rdy_stray = 1'b0, suppress = 1'b0;
  logic           mult_rdy;
  logic [15:0]    mult_res = '0;

  assign mult_rdy = rdy_real | rdy_stray;

  mult_share_arbiter #(
    .NUM_REQ    (N),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .done    (done),
    .res_out (res_out),
    .err     (err),
    .mult_ld (mult_ld),
    .mult_a  (mult_a),
    .mult_b  (mult_b),
    .mult_rdy(mult_rdy),
    .mult_res(mult_res)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier: product valid in the 9th cycle after the load cycle.
  int rdy_at = -1;
  always @(negedge clk) begin
    if (reset) begin
      rdy_at = -1;
    end else if (mult_ld) begin
      rdy_at   = cyc + LAT;
      mult_res = 16'(mult_a) * 16'(mult_b);
    end
  end

  always @(posedge clk) begin
    #1;
    rdy_real = (cyc == rdy_at) && !suppress;
  end

  // Reference model: one operation at a time, tracked by owner and cycles since grant.
  bit         m_valid = 0, m_busy = 0, m_fin = 0, m_err = 0;
  int         m_owner = 0, m_ptr = 0, m_age = 0;
  logic [7:0] m_a = '0, m_b = '0;
  logic [15:0] m_res = '0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_valid = 1; m_busy = 0; m_fin = 0; m_err = 0;
      m_ptr = 0; m_owner = 0; m_a = '0; m_b = '0; m_res = '0;
    end else if (m_fin) begin
      m_fin  = 0;
      m_busy = 0;
      m_err  = 0;
      m_ptr  = (m_owner + 1) % N;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy && req[(m_ptr + k) % N]) begin
          m_busy  = 1;
          m_owner = (m_ptr + k) % N;
          m_age   = 0;
          m_a     = a_in[8*m_owner +: 8];
          m_b     = b_in[8*m_owner +: 8];
        end
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (mult_rdy) begin
      m_res = 16'(m_a) * 16'(m_b);
      m_fin = 1;
    end
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
    else if (m_age == TO) begin
      m_res = '0;
      m_err = 1;
      m_fin = 1;
    end
`endif
    else begin
      m_age++;
    end
  end

  // Per-cycle compare plus an event log for the directed checks.
  int          done_idx[$];
  logic [15:0] done_res[$];
  int          done_err[$];
  int          done_cyc[$];
  int          ld_cyc[$];

  always @(negedge clk) begin
    logic [N-1:0] eg, ed;
    if (m_valid) begin
      eg = '0;
      ed = '0;
      if (m_busy) eg[m_owner] = 1'b1;
      if (m_fin)  ed[m_owner] = 1'b1;
      chk("gnt", gnt, eg);
      chk("done", done, ed);
      chk("mult_ld", mult_ld, m_busy && !m_fin && m_age == 0);
      chk("err", err, m_fin && m_err);
      chk("res_out", res_out, m_res);
      if (m_busy) begin
        chk("mult_a", mult_a, m_a);
        chk("mult_b", mult_b, m_b);
      end
      if (mult_ld === 1'b1) ld_cyc.push_back(cyc);
      if (done !== '0) begin
        for (int i = 0; i < N; i++) if (done[i] === 1'b1) done_idx.push_back(i);
        done_res.push_back(res_out);
        done_err.push_back(int'(err));
        done_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    done_idx.delete(); done_res.delete(); done_err.delete(); done_cyc.delete(); ld_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int i;
    i = 0;
    while (done_idx.size() < n && i < budget) begin
      tick();
      i++;
    end
    chk("done_arrival", 32'(done_idx.size() >= n), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t0;
    int exp_idx[5];
    logic [15:0] exp_res[5];

    // Single request, latency 12 cycles inclusive of the request cycle.
    do_reset();
    tick();
    clear_logs();
    a_in[7:0] = 8'd12; b_in[7:0] = 8'd34;
    req = 4'b0001;
    t0 = cyc;
    tick();
    req = '0;
    wait_done(1, 40);
    if (done_idx.size() >= 1) begin
      chk("s1_idx", done_idx[0], 0);
      chk("s1_res", done_res[0], 16'd408);
      chk("s1_lat", done_cyc[0] - t0, 11);
    end
    if (ld_cyc.size() >= 1) chk("s1_ld", ld_cyc[0] - t0, 1);

    // All four requesting from reset: 0,1,2,3,0.
    reset = 1'b1;
    req = 4'b1111;
    a_in = {8'hFF, 8'd7, 8'd20, 8'd10};
    b_in = {8'hFF, 8'd9, 8'd4, 8'd3};
    tick();
    tick();
    clear_logs();
    reset = 1'b0;
    wait_done(5, 100);
    req = '0;
    exp_idx = '{0, 1, 2, 3, 0};
    exp_res = '{16'd30, 16'd80, 16'd63, 16'hFE01, 16'd30};
    for (int i = 0; i < 5; i++) begin
      if (done_idx.size() > i) begin
        chk("s2_idx", done_idx[i], exp_idx[i]);
        chk("s2_res", done_res[i], exp_res[i]);
      end
    end

    // Fairness: req0 held, req2 arrives mid-operation.
    do_reset();
    clear_logs();
    a_in = {8'd0, 8'd5, 8'd0, 8'd2};
    b_in = {8'd0, 8'd7, 8'd0, 8'd3};
    req[0] = 1'b1;
    repeat (4) tick();
    req[2] = 1'b1;
    wait_done(2, 60);
    req[2] = 1'b0;
    wait_done(3, 60);
    req[0] = 1'b0;
    exp_idx = '{0, 2, 0, 0, 0};
    exp_res = '{16'd6, 16'd35, 16'd6, 16'd0, 16'd0};
    for (int i = 0; i < 3; i++) begin
      if (done_idx.size() > i) begin
        chk("s3_idx", done_idx[i], exp_idx[i]);
        chk("s3_res", done_res[i], exp_res[i]);
      end
    end

    // Operand isolation and a stray mult_rdy in IDLE.
    do_reset();
    clear_logs();
    a_in = '0; b_in = '0;
    a_in[15:8] = 8'd11; b_in[15:8] = 8'd13;
    req = 4'b0010;
    tick();
    req = '0;
    repeat (4) tick();
    a_in[15:8] = 8'd99;
    wait_done(1, 40);
    if (done_res.size() >= 1) chk("s4_res", done_res[0], 16'd143);
    repeat (3) tick();
    rdy_stray = 1'b1;
    tick();
    rdy_stray = 1'b0;
    repeat (5) tick();
    chk("s4_stray_done", done_idx.size(), 1);
    chk("s4_stray_gnt", gnt, 4'b0000);

    // Reset during WAIT discards the operation.
    clear_logs();
    a_in[7:0] = 8'd9; b_in[7:0] = 8'd9;
    req = 4'b0001;
    tick();
    req = '0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s5_gnt", gnt, 4'b0000);
    chk("s5_res", res_out, 16'd0);
    chk("s5_ma", mult_a, 8'd0);
    chk("s5_mb", mult_b, 8'd0);
    chk("s5_ld", mult_ld, 1'b0);
    repeat (15) tick();
    chk("s5_no_done", done_idx.size(), 0);
    a_in[15:8] = 8'd3; b_in[15:8] = 8'd5;
    req = 4'b0010;
    tick();
    req = '0;
    wait_done(1, 40);
    if (done_idx.size() >= 1) begin
      chk("s5_idx", done_idx[0], 1);
      chk("s5_res15", done_res[0], 16'd15);
    end

`ifdef MULT_SHARE_ARB_TIMEOUT_EN
    // Suppressed multiplier: timeout after 32 WAIT cycles, then requester 1 served.
    do_reset();
    clear_logs();
    a_in = {16'd0, 8'd6, 8'd4};
    b_in = {16'd0, 8'd7, 8'd4};
    suppress = 1'b1;
    req = 4'b0011;
    tick();
    req = 4'b0010;
    wait_done(1, 60);
    suppress = 1'b0;
    wait_done(2, 40);
    req = '0;
    if (done_idx.size() >= 2 && ld_cyc.size() >= 1) begin
      chk("to_idx", done_idx[0], 0);
      chk("to_err", done_err[0], 1);
      chk("to_res", done_res[0], 16'd0);
      chk("to_lat", done_cyc[0] - ld_cyc[0], 33);
      chk("to_next_idx", done_idx[1], 1);
      chk("to_next_err", done_err[1], 0);
      chk("to_next_res", done_res[1], 16'd42);
    end
`else
    // No timeout build: a silent multiplier keeps the grant indefinitely.
    do_reset();
    clear_logs();
    suppress = 1'b1;
    req = 4'b0001;
    tick();
    req = '0;
    repeat (60) tick();
    chk("hang_no_done", done_idx.size(), 0);
    chk("hang_gnt", gnt, 4'b0001);
    chk("hang_err", err, 1'b0);
    suppress = 1'b0;
`endif

    // Randomized traffic with mid-flight operand changes, stray pulses and resets.
    do_reset();
    clear_logs();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) req[i] = ($urandom_range(0, 7) == 0);
        else if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
      end
      a_in = 32'($urandom);
      b_in = 32'($urandom);
      rdy_stray = (!m_busy || m_fin || m_age == 0) && ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    req = '0;
    rdy_stray = 1'b0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
